// File: rtl/guitar_effect_pkg.sv
// guitar_effect shared constants: register map, status bits, sample type.
// Imported by the register-file top and the testbench.
package guitar_effect_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam logic [4:0] ADD_DISTORTION_GAIN  = 5'd1;
  localparam logic [4:0] ADD_DISTORTION_BOOST = 5'd2;
  localparam logic [4:0] ADD_STATUS           = 5'd3;
  localparam logic [4:0] ADD_OUTPUT           = 5'd5;
  localparam logic [4:0] ADD_INPUT            = 5'd6;

  localparam int ST_ENABLE  = 0;
  localparam int ST_VALID   = 1;
  localparam int ST_CLIPPED = 2;

endpackage

// File: rtl/distortion_core.sv
// Three-stage gain / hard-clip / boost pipeline with bypass.
// Enable is latched at capture and travels with the sample.
module distortion_core #(
  parameter int DATA_W     = 16,
  parameter int GAIN_W     = 8,
  parameter int CLIP_LEVEL = 8192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_v,
  input  logic signed [DATA_W-1:0] x,
  input  logic [GAIN_W-1:0]        gain,
  input  logic [GAIN_W-1:0]        boost,
  input  logic                     enable,
  output logic                     out_v,
  output logic signed [DATA_W-1:0] y,
  output logic                     clip
);

  localparam int PW = DATA_W + GAIN_W + 1;

  localparam logic signed [PW-1:0] HI = PW'(CLIP_LEVEL);
  localparam logic signed [PW-1:0] LO = -HI;
  localparam logic signed [PW-1:0] MAXV = PW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = -PW'(2 ** (DATA_W - 1));

  logic                     v1, v2;
  logic                     en1, en2;
  logic                     clip2, clip_nxt;
  logic signed [PW-1:0]     p1, p_nxt, q;
  logic signed [DATA_W-1:0] c2, c_nxt, y_nxt;

  always_comb begin
    if (enable) p_nxt = PW'(x) * PW'($signed({1'b0, gain}));
    else        p_nxt = PW'(x);
  end

  // Bypassed samples are already in range, so the low bits are exact.
  always_comb begin
    c_nxt    = p1[DATA_W-1:0];
    clip_nxt = 1'b0;
    if (en1) begin
      if (p1 > HI) begin
        c_nxt    = HI[DATA_W-1:0];
        clip_nxt = 1'b1;
      end else if (p1 < LO) begin
        c_nxt    = LO[DATA_W-1:0];
        clip_nxt = 1'b1;
      end
    end
  end

  assign q = PW'(c2) * PW'($signed({1'b0, boost}));

  always_comb begin
    y_nxt = c2;
    if (en2) begin
      if (q > MAXV)      y_nxt = MAXV[DATA_W-1:0];
      else if (q < MINV) y_nxt = MINV[DATA_W-1:0];
      else               y_nxt = q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      out_v <= 1'b0;
      en1   <= 1'b0;
      en2   <= 1'b0;
      p1    <= '0;
      c2    <= '0;
      clip2 <= 1'b0;
      y     <= '0;
      clip  <= 1'b0;
    end else begin
      v1    <= in_v;
      en1   <= enable;
      p1    <= p_nxt;
      v2    <= v1;
      en2   <= en1;
      c2    <= c_nxt;
      clip2 <= clip_nxt;
      out_v <= v2;
      y     <= y_nxt;
      clip  <= clip2;
    end
  end

endmodule

// File: rtl/guitar_effect.sv
// Avalon-MM distortion effect: register file, sample tick detect,
// registered read mux around the distortion_core pipeline.
module guitar_effect
  import guitar_effect_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int CLIP_LEVEL = 8192,
  parameter int GAIN_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_500,
  input  logic [4:0]  avl_address,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic        avl_read,
  output logic [31:0] avl_readdata
);

  logic                     clk_500_q, tick;
  logic [GAIN_W-1:0]        gain, boost;
  logic                     enable, valid, clipped;
  logic signed [DATA_W-1:0] inreg, outreg;
  logic                     core_v, core_clip;
  logic signed [DATA_W-1:0] core_y;
  logic [31:0]              rnext;
  logic                     unused_wd;

  assign unused_wd = ^avl_writedata[31:DATA_W];

  assign tick = clk_500 & ~clk_500_q;

  distortion_core #(
    .DATA_W     (DATA_W),
    .GAIN_W     (GAIN_W),
    .CLIP_LEVEL (CLIP_LEVEL)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .in_v   (tick),
    .x      (inreg),
    .gain   (gain),
    .boost  (boost),
    .enable (enable),
    .out_v  (core_v),
    .y      (core_y),
    .clip   (core_clip)
  );

  always_comb begin
    rnext = '0;
    case (avl_address)
      ADD_DISTORTION_GAIN:  rnext = 32'(gain);
      ADD_DISTORTION_BOOST: rnext = 32'(boost);
      ADD_STATUS: begin
        rnext[ST_ENABLE]  = enable;
        rnext[ST_VALID]   = valid;
        rnext[ST_CLIPPED] = clipped;
      end
      ADD_OUTPUT:           rnext = 32'(outreg);
      ADD_INPUT:            rnext = 32'(inreg);
      default:              rnext = '0;
    endcase
  end

  // Pipeline results are applied last so set beats same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_500_q    <= 1'b0;
      avl_readdata <= '0;
      gain         <= GAIN_W'(1);
      boost        <= GAIN_W'(1);
      enable       <= 1'b1;
      valid        <= 1'b0;
      clipped      <= 1'b0;
      inreg        <= '0;
      outreg       <= '0;
    end else begin
      clk_500_q    <= clk_500;
      avl_readdata <= rnext;
      if (avl_write) begin
        case (avl_address)
          ADD_DISTORTION_GAIN:  gain  <= avl_writedata[GAIN_W-1:0];
          ADD_DISTORTION_BOOST: boost <= avl_writedata[GAIN_W-1:0];
          ADD_STATUS: begin
            enable <= avl_writedata[ST_ENABLE];
            if (avl_writedata[ST_CLIPPED]) clipped <= 1'b0;
          end
          ADD_INPUT:            inreg <= avl_writedata[DATA_W-1:0];
          default: ;
        endcase
      end
      if (avl_read && avl_address == ADD_OUTPUT) valid <= 1'b0;
      if (core_v) begin
        outreg <= core_y;
        valid  <= 1'b1;
        if (core_clip) clipped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_guitar_effect.sv
// Self-checking bench for guitar_effect against an arithmetic model.
// Each scenario task drives the bus and checks readback inline.
module tb_guitar_effect;
  import guitar_effect_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_500 = 1'b0;
  logic [4:0]  avl_address = '0;
  logic        avl_write = 1'b0;
  logic [31:0] avl_writedata = '0;
  logic        avl_read = 1'b0;
  logic [31:0] avl_readdata;

  int checks = 0;
  int errors = 0;

  guitar_effect dut (
    .clk           (clk),
    .reset         (reset),
    .clk_500       (clk_500),
    .avl_address   (avl_address),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_read      (avl_read),
    .avl_readdata  (avl_readdata)
  );

  always #5 clk = ~clk;

  function automatic int clamp_p(int p);
    if (p > 8192) return 8192;
    if (p < -8192) return -8192;
    return p;
  endfunction

  function automatic int fx(int x, int g, int b, bit en);
    int q;
    if (!en) return x;
    q = clamp_p(x * g) * b;
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return q;
  endfunction

  function automatic bit fclip(int x, int g, bit en);
    return en && (x * g > 8192 || x * g < -8192);
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avl_address = a;
    avl_writedata = d;
    avl_write = 1'b1;
    @(negedge clk);
    avl_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic side,
                    output logic [31:0] d);
    @(negedge clk);
    avl_address = a;
    avl_read = side;
    @(negedge clk);
    avl_read = 1'b0;
    d = avl_readdata;
  endtask

  task automatic pulse_wait();
    @(negedge clk);
    clk_500 = 1'b1;
    @(negedge clk);
    clk_500 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (avl_readdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata got %h exp %h", avl_readdata, 32'd0);
    end
    reset = 1'b0;
    rd(ADD_DISTORTION_GAIN, 1'b0, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL reset_gain got %h exp %h", d, 32'd1); end
    rd(ADD_DISTORTION_BOOST, 1'b0, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL reset_boost got %h exp %h", d, 32'd1); end
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h1); end
    rd(ADD_OUTPUT, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_output got %h exp %h", d, 32'd0); end
    rd(ADD_INPUT, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_input got %h exp %h", d, 32'd0); end
    wr(5'd7, 32'hFFFF_FFFF);
    rd(5'd7, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h exp %h", d, 32'd0); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [31:0] rec [5];
    wr(ADD_DISTORTION_GAIN, 32'd1);
    wr(ADD_DISTORTION_BOOST, 32'd2);
    wr(ADD_INPUT, 32'd10);
    @(negedge clk);
    avl_address = ADD_OUTPUT;
    clk_500 = 1'b1;
    @(negedge clk);
    clk_500 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rec[k] = avl_readdata;
    end
    checks++;
    if (rec[3] !== 32'd0) begin errors++; $display("FAIL latency_early got %h exp %h", rec[3], 32'd0); end
    checks++;
    if (rec[4] !== 32'd20) begin errors++; $display("FAIL latency_out got %h exp %h", rec[4], 32'd20); end
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL valid_set got %h exp %h", d, 32'h3); end
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'd20) begin errors++; $display("FAIL basic_out got %h exp %h", d, 32'd20); end
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL valid_clear got %h exp %h", d, 32'h1); end
  endtask

  task automatic test_ro_output();
    logic [31:0] d;
    wr(ADD_OUTPUT, 32'd10);
    wr(ADD_OUTPUT, 32'd20);
    wr(ADD_OUTPUT, 32'd10);
    rd(ADD_OUTPUT, 1'b0, d);
    checks++;
    if (d !== 32'd20) begin errors++; $display("FAIL output_ro got %h exp %h", d, 32'd20); end
  endtask

  task automatic test_clip();
    logic [31:0] d;
    wr(ADD_DISTORTION_GAIN, 32'd200);
    wr(ADD_DISTORTION_BOOST, 32'd1);
    wr(ADD_INPUT, 32'd100);
    pulse_wait();
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'd8192) begin errors++; $display("FAIL clip_pos got %h exp %h", d, 32'd8192); end
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL clip_flag got %h exp %h", d, 32'h5); end
    wr(ADD_INPUT, 32'(-100));
    pulse_wait();
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'hFFFF_E000) begin errors++; $display("FAIL clip_neg got %h exp %h", d, 32'hFFFF_E000); end
    wr(ADD_STATUS, 32'h5);
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL clip_clear got %h exp %h", d, 32'h1); end
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    wr(ADD_STATUS, 32'h0);
    wr(ADD_DISTORTION_GAIN, 32'd5);
    wr(ADD_INPUT, 32'(-1234));
    pulse_wait();
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'(-1234)) begin errors++; $display("FAIL bypass_out got %h exp %h", d, 32'(-1234)); end
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL bypass_status got %h exp %h", d, 32'h0); end
    wr(ADD_STATUS, 32'h1);
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    wr(ADD_DISTORTION_GAIN, 32'd200);
    wr(ADD_DISTORTION_BOOST, 32'd255);
    wr(ADD_INPUT, 32'd100);
    pulse_wait();
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'd32767) begin errors++; $display("FAIL sat_pos got %h exp %h", d, 32'd32767); end
    wr(ADD_INPUT, 32'(-100));
    pulse_wait();
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'hFFFF_8000) begin errors++; $display("FAIL sat_neg got %h exp %h", d, 32'hFFFF_8000); end
    wr(ADD_STATUS, 32'h5);
  endtask

  task automatic test_hold_high();
    logic [31:0] d;
    wr(ADD_DISTORTION_GAIN, 32'd1);
    wr(ADD_DISTORTION_BOOST, 32'd1);
    wr(ADD_INPUT, 32'd7);
    @(negedge clk);
    clk_500 = 1'b1;
    repeat (6) @(negedge clk);
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL hold_first got %h exp %h", d, 32'd7); end
    wr(ADD_INPUT, 32'd9);
    repeat (30) @(negedge clk);
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL hold_status got %h exp %h", d, 32'h1); end
    rd(ADD_OUTPUT, 1'b0, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL hold_out got %h exp %h", d, 32'd7); end
    clk_500 = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    wr(ADD_INPUT, 32'd300);
    @(negedge clk);
    avl_address = ADD_INPUT;
    avl_writedata = 32'd555;
    avl_write = 1'b1;
    clk_500 = 1'b1;
    @(negedge clk);
    avl_write = 1'b0;
    clk_500 = 1'b0;
    repeat (3) @(negedge clk);
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'(fx(300, 1, 1, 1'b1))) begin
      errors++; $display("FAIL same_cycle_old got %h exp %h", d, 32'(fx(300, 1, 1, 1'b1)));
    end
    pulse_wait();
    rd(ADD_OUTPUT, 1'b1, d);
    checks++;
    if (d !== 32'(fx(555, 1, 1, 1'b1))) begin
      errors++; $display("FAIL same_cycle_new got %h exp %h", d, 32'(fx(555, 1, 1, 1'b1)));
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int x, g, b;
    bit en, cl;
    for (int i = 0; i < 24; i++) begin
      x  = int'($urandom_range(0, 65535)) - 32768;
      g  = (i == 0) ? 0 : int'($urandom_range(0, 255));
      b  = (i == 1) ? 0 : int'($urandom_range(0, 255));
      en = (i < 2) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      cl = fclip(x, g, en);
      wr(ADD_STATUS, {29'd0, 1'b1, 1'b0, en});
      wr(ADD_DISTORTION_GAIN, 32'(g));
      wr(ADD_DISTORTION_BOOST, 32'(b));
      wr(ADD_INPUT, 32'(x));
      pulse_wait();
      rd(ADD_STATUS, 1'b0, d);
      checks++;
      if (d !== {29'd0, cl, 1'b1, en}) begin
        errors++; $display("FAIL rand_status[%0d] got %h exp %h", i, d, {29'd0, cl, 1'b1, en});
      end
      rd(ADD_OUTPUT, 1'b1, d);
      checks++;
      if (d !== 32'(fx(x, g, b, en))) begin
        errors++; $display("FAIL rand_out[%0d] x=%0d g=%0d b=%0d en=%0d got %h exp %h",
                            i, x, g, b, en, d, 32'(fx(x, g, b, en)));
      end
    end
    wr(ADD_STATUS, 32'h5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] u [$];
    int v [4];
    wr(ADD_DISTORTION_GAIN, 32'd1);
    wr(ADD_DISTORTION_BOOST, 32'd1);
    for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 1000)) + i * 2000 - 3500;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) q.push_back(avl_readdata);
      avl_address = ADD_INPUT;
      avl_writedata = 32'(v[i]);
      avl_write = 1'b1;
      clk_500 = 1'b0;
      @(negedge clk);
      avl_write = 1'b0;
      avl_address = ADD_OUTPUT;
      clk_500 = 1'b1;
    end
    @(negedge clk);
    q.push_back(avl_readdata);
    clk_500 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      q.push_back(avl_readdata);
    end
    foreach (q[k]) if (u.size() == 0 || u[$] !== q[k]) u.push_back(q[k]);
    checks++;
    if (u.size() < 4) begin
      errors++; $display("FAIL b2b_count got %0d exp %0d", u.size(), 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (u[u.size() - 4 + i] !== 32'(fx(v[i], 1, 1, 1'b1))) begin
          errors++; $display("FAIL b2b_out[%0d] got %h exp %h", i,
                              u[u.size() - 4 + i], 32'(fx(v[i], 1, 1, 1'b1)));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(ADD_INPUT, 32'd1111);
    pulse_wait();
    rd(ADD_OUTPUT, 1'b0, d);
    checks++;
    if (d !== 32'd1111) begin errors++; $display("FAIL pre_reset got %h exp %h", d, 32'd1111); end
    wr(ADD_INPUT, 32'd2222);
    @(negedge clk);
    clk_500 = 1'b1;
    @(negedge clk);
    clk_500 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    rd(ADD_OUTPUT, 1'b0, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL mid_reset_out got %h exp %h", d, 32'd0); end
    rd(ADD_STATUS, 1'b0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL mid_reset_status got %h exp %h", d, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ro_output();
    test_clip();
    test_bypass();
    test_saturate();
    test_hold_high();
    test_same_cycle();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
